// File: rtl/hazard_pkg.sv
// Shared types for the EX operand-forwarding control slice.
// Optional feature macro used by the top: HAZARD_PERF_EN.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
    logic [REG_W-1:0] rd;
    logic             wren;
    logic             load;
  } ex_shadow_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wren;
    logic             load;
  } mem_shadow_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wren;
  } wb_shadow_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_gen.sv
// Forward-select comparator for a single EX operand. MEM beats WB; x0 never forwarded.
module fwd_sel_gen
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_rs_used,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_wren,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_wren,
  output logic [1:0]       o_sel
);

  fwd_sel_e sel;

  // Pick the youngest in-flight producer of the operand register
  always_comb begin
    sel = FWD_NONE;
    if (i_rs_used && (i_rs != REG_ZERO)) begin
      if (i_mem_wren && (i_mem_rd == i_rs)) begin
        sel = FWD_MEM;
      end else if (i_wb_wren && (i_wb_rd == i_rs)) begin
        sel = FWD_WB;
      end
    end
  end

  assign o_sel = sel;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX forwarding / load-use hazard control with EX, MEM, WB shadow state.
// Define HAZARD_PERF_EN to build the saturating stall and forward counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_rs1_addr_id,
  input  logic [REG_AW-1:0] i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [REG_AW-1:0] i_rd_addr_id,
  input  logic              i_rd_wren_id,
  input  logic              i_is_load_id,
  input  logic              i_flush_ex,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic              o_stall,
  output logic              o_bubble_ex,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_fwd_cnt
);

  ex_shadow_t  ex_q,  ex_d;
  mem_shadow_t mem_q, mem_d;
  wb_shadow_t  wb_q,  wb_d;
  logic        load_use;
  logic        unused_mem_load;

  assign unused_mem_load = mem_q.load;

  // Hazard detection and shadow-pipeline advance; flush overrides the stall
  always_comb begin
    load_use = ex_q.load && ex_q.wren && (ex_q.rd != REG_ZERO) &&
               ((i_rs1_used_id && (i_rs1_addr_id == ex_q.rd)) ||
                (i_rs2_used_id && (i_rs2_addr_id == ex_q.rd)));
    o_stall     = load_use && !i_flush_ex;
    o_bubble_ex = load_use || i_flush_ex;

    ex_d = '0;
    if (!o_bubble_ex) begin
      ex_d.rs1      = i_rs1_addr_id;
      ex_d.rs2      = i_rs2_addr_id;
      ex_d.rs1_used = i_rs1_used_id;
      ex_d.rs2_used = i_rs2_used_id;
      ex_d.rd       = i_rd_addr_id;
      ex_d.wren     = i_rd_wren_id;
      ex_d.load     = i_is_load_id;
    end

    mem_d.rd   = ex_q.rd;
    mem_d.wren = ex_q.wren;
    mem_d.load = ex_q.load;

    wb_d.rd    = mem_q.rd;
    wb_d.wren  = mem_q.wren;
  end

  // Shadow registers advance every edge; MEM and WB never stall
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_sel_gen u_fwd_a (
    .i_rs       (ex_q.rs1),
    .i_rs_used  (ex_q.rs1_used),
    .i_mem_rd   (mem_q.rd),
    .i_mem_wren (mem_q.wren),
    .i_wb_rd    (wb_q.rd),
    .i_wb_wren  (wb_q.wren),
    .o_sel      (o_forward_a)
  );

  fwd_sel_gen u_fwd_b (
    .i_rs       (ex_q.rs2),
    .i_rs_used  (ex_q.rs2_used),
    .i_mem_rd   (mem_q.rd),
    .i_mem_wren (mem_q.wren),
    .i_wb_rd    (wb_q.rd),
    .i_wb_wren  (wb_q.wren),
    .o_sel      (o_forward_b)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (o_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (((o_forward_a | o_forward_b) != 2'b00) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_fwd_cnt   = fwd_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed hazard scenarios followed
// by random instruction streams, checked against an instruction-history model.
module tb_hazard_fwd_ctrl;

  typedef struct {
    int unsigned rs1;
    int unsigned rs2;
    bit          u1;
    bit          u2;
    int unsigned rd;
    bit          wr;
    bit          ld;
  } instr_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [4:0]  i_rs1_addr_id = '0;
  logic [4:0]  i_rs2_addr_id = '0;
  logic        i_rs1_used_id = 1'b0;
  logic        i_rs2_used_id = 1'b0;
  logic [4:0]  i_rd_addr_id = '0;
  logic        i_rd_wren_id = 1'b0;
  logic        i_is_load_id = 1'b0;
  logic        i_flush_ex = 1'b0;
  logic [1:0]  o_forward_a;
  logic [1:0]  o_forward_b;
  logic        o_stall;
  logic        o_bubble_ex;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_fwd_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Instructions that entered EX, newest first: [0]=EX, [1]=MEM, [2]=WB
  instr_t      hist[$];
  int unsigned m_stall_cnt;
  int unsigned m_fwd_cnt;
  bit          last_stall;
  logic [1:0]  obs_fa, obs_fb;
  logic        obs_stall, obs_bub;

  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_rs1_used_id (i_rs1_used_id),
    .i_rs2_used_id (i_rs2_used_id),
    .i_rd_addr_id  (i_rd_addr_id),
    .i_rd_wren_id  (i_rd_wren_id),
    .i_is_load_id  (i_is_load_id),
    .i_flush_ex    (i_flush_ex),
    .o_forward_a   (o_forward_a),
    .o_forward_b   (o_forward_b),
    .o_stall       (o_stall),
    .o_bubble_ex   (o_bubble_ex),
    .o_stall_cnt   (o_stall_cnt),
    .o_fwd_cnt     (o_fwd_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic instr_t mk(int unsigned rd, int unsigned rs1, int unsigned rs2,
                                bit u1, bit u2, bit wr, bit ld);
    instr_t r;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.wr = wr; r.ld = ld;
    return r;
  endfunction

  function automatic instr_t nop();
    return mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.rs1 = $urandom_range(0, 7);
    r.rs2 = $urandom_range(0, 7);
    r.rd  = $urandom_range(0, 7);
    r.u1  = ($urandom_range(0, 3) != 0);
    r.u2  = ($urandom_range(0, 1) != 0);
    r.wr  = ($urandom_range(0, 4) != 0);
    r.ld  = r.wr && ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // Distance to the nearest older writer of the EX operand (1=MEM, 2=WB), 0 if none
  function automatic logic [1:0] model_fwd(bit use_rs2);
    instr_t e = hist[0];
    int unsigned src = use_rs2 ? e.rs2 : e.rs1;
    bit used = use_rs2 ? e.u2 : e.u1;
    if (!used || src == 0) return 2'd0;
    for (int d = 1; d <= 2; d++) begin
      if (hist[d].wr && hist[d].rd == src) return 2'(d);
    end
    return 2'd0;
  endfunction

  function automatic bit model_load_use(instr_t id);
    instr_t e = hist[0];
    return e.ld && e.wr && e.rd != 0 &&
           ((id.u1 && id.rs1 == e.rd) || (id.u2 && id.rs2 == e.rd));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(nop());
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endtask

  // One cycle: present ID instruction, check at negedge, advance model at posedge
  task automatic step(input instr_t ins, input bit flush);
    bit         lu, e_stall, e_bub;
    logic [1:0] e_fa, e_fb;
    i_rs1_addr_id = 5'(ins.rs1);
    i_rs2_addr_id = 5'(ins.rs2);
    i_rs1_used_id = ins.u1;
    i_rs2_used_id = ins.u2;
    i_rd_addr_id  = 5'(ins.rd);
    i_rd_wren_id  = ins.wr;
    i_is_load_id  = ins.ld;
    i_flush_ex    = flush;
    @(negedge i_clk);
    lu      = model_load_use(ins);
    e_stall = lu && !flush;
    e_bub   = lu || flush;
    e_fa    = model_fwd(1'b0);
    e_fb    = model_fwd(1'b1);
    check("fwd_a", 32'(o_forward_a), 32'(e_fa));
    check("fwd_b", 32'(o_forward_b), 32'(e_fb));
    check("stall", 32'(o_stall), 32'(e_stall));
    check("bubble", 32'(o_bubble_ex), 32'(e_bub));
`ifdef HAZARD_PERF_EN
    check("stall_cnt", o_stall_cnt, m_stall_cnt);
    check("fwd_cnt", o_fwd_cnt, m_fwd_cnt);
`else
    check("stall_cnt", o_stall_cnt, 32'd0);
    check("fwd_cnt", o_fwd_cnt, 32'd0);
`endif
    obs_fa = o_forward_a; obs_fb = o_forward_b;
    obs_stall = o_stall;  obs_bub = o_bubble_ex;
    last_stall = e_stall;
    @(posedge i_clk);
    if (e_stall) m_stall_cnt++;
    if (e_fa != 0 || e_fb != 0) m_fwd_cnt++;
    hist.push_front(e_bub ? nop() : ins);
    void'(hist.pop_back());
    #1;
  endtask

  initial begin
    instr_t id;
    bit     fl;
    model_reset();
    #12;
    check("rst_fwd_a", 32'(o_forward_a), 32'd0);
    check("rst_fwd_b", 32'(o_forward_b), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_bubble", 32'(o_bubble_ex), 32'd0);
    check("rst_cnt", o_stall_cnt | o_fwd_cnt, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;

    // add x5; add rs1=x5 -> MEM forward on A only
    step(mk(5, 1, 2, 1, 1, 1, 0), 0);
    step(mk(8, 5, 6, 1, 1, 1, 0), 0);
    step(nop(), 0);
    check("t1_fa", 32'(obs_fa), 32'(2'b01));
    check("t1_fb", 32'(obs_fb), 32'(2'b00));

    // addi x7; nop; sub rs2=x7 -> WB forward on B
    step(mk(7, 0, 0, 1, 0, 1, 0), 0);
    step(nop(), 0);
    step(mk(10, 1, 7, 1, 1, 1, 0), 0);
    step(nop(), 0);
    check("t2_fb", 32'(obs_fb), 32'(2'b10));

    // addi x3; addi x3; add rs1=x3 -> MEM wins over WB
    step(mk(3, 0, 0, 1, 0, 1, 0), 0);
    step(mk(3, 3, 0, 1, 0, 1, 0), 0);
    step(mk(4, 3, 0, 1, 0, 1, 0), 0);
    step(nop(), 0);
    check("t3_fa", 32'(obs_fa), 32'(2'b01));

    // lw x9; add rs1=x9 -> one stall, then load result reaches the add from WB
    step(mk(9, 2, 0, 1, 0, 1, 1), 0);
    step(mk(11, 9, 4, 1, 1, 1, 0), 0);
    check("t4_stall", 32'(obs_stall), 32'd1);
    check("t4_bubble", 32'(obs_bub), 32'd1);
    step(mk(11, 9, 4, 1, 1, 1, 0), 0);
    check("t4_stall_once", 32'(obs_stall), 32'd0);
    step(nop(), 0);
    check("t4_fa", 32'(obs_fa), 32'(2'b10));

    // lw x9 with dependent add and a flush in the same cycle
    step(mk(9, 2, 0, 1, 0, 1, 1), 0);
    step(mk(11, 9, 4, 1, 1, 1, 0), 1);
    check("t5_stall", 32'(obs_stall), 32'd0);
    check("t5_bubble", 32'(obs_bub), 32'd1);
    step(nop(), 0);
    check("t5_fa", 32'(obs_fa), 32'd0);

    // writes to x0 are never forwarded
    step(mk(0, 1, 1, 1, 1, 1, 0), 0);
    step(mk(0, 0, 0, 1, 1, 1, 1), 0);
    step(mk(6, 0, 0, 1, 1, 1, 0), 0);
    check("t6_stall_x0", 32'(obs_stall), 32'd0);
    step(nop(), 0);
    check("t6_fa", 32'(obs_fa), 32'd0);
    check("t6_fb", 32'(obs_fb), 32'd0);

    // async reset pulse while a forward is active
    step(mk(5, 0, 0, 0, 0, 1, 0), 0);
    step(mk(6, 5, 5, 1, 1, 1, 0), 0);
    i_rs1_used_id = 1'b0; i_rs2_used_id = 1'b0; i_rd_wren_id = 1'b0; i_is_load_id = 1'b0;
    #2;
    check("pre_rst_fa", 32'(o_forward_a), 32'(2'b01));
    i_reset = 1'b0;
    #1;
    check("async_rst_fa", 32'(o_forward_a), 32'd0);
    check("async_rst_fb", 32'(o_forward_b), 32'd0);
    check("async_rst_stall", 32'(o_stall | o_bubble_ex), 32'd0);
    check("async_rst_cnt", o_stall_cnt | o_fwd_cnt, 32'd0);
    #1;
    i_reset = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    step(nop(), 0);
    check("post_rst_fa", 32'(obs_fa), 32'd0);

    // random streams; the core holds the ID instruction while stalled
    id = rand_instr();
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 11) == 0);
      step(id, fl);
      if (!last_stall) id = rand_instr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
